// File: rtl/ucsbece154b_perf_pkg.sv
// Shared definitions for the performance monitor: register map, FSM states,
// status bit positions and counter indices.
package ucsbece154b_perf_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  localparam logic [2:0] ADDR_CYC      = 3'd0;
  localparam logic [2:0] ADDR_BR_TOT   = 3'd1;
  localparam logic [2:0] ADDR_BR_MISS  = 3'd2;
  localparam logic [2:0] ADDR_JMP_TOT  = 3'd3;
  localparam logic [2:0] ADDR_JMP_MISS = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;
  localparam logic [2:0] ADDR_HALT_PC  = 3'd6;
  localparam logic [2:0] ADDR_ZERO     = 3'd7;

  localparam int NUM_CNT      = 5;
  localparam int CNT_CYC      = 0;
  localparam int CNT_BR_TOT   = 1;
  localparam int CNT_BR_MISS  = 2;
  localparam int CNT_JMP_TOT  = 3;
  localparam int CNT_JMP_MISS = 4;

  localparam int STAT_DONE    = 0;
  localparam int STAT_TIMEOUT = 1;
  localparam int STAT_OVF     = 2;

  function automatic logic [31:0] pack_status(input logic ovf, input logic timeout,
                                              input logic done);
    logic [31:0] s;
    s = '0;
    s[STAT_OVF]     = ovf;
    s[STAT_TIMEOUT] = timeout;
    s[STAT_DONE]    = done;
    return s;
  endfunction

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// Saturating up-counter: holds at all-ones; clr has priority over inc.
// sat flags that the counter currently sits at its maximum.
module ucsbece154b_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         sat
);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat = &cnt_q;
  assign q   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ucsbece154b_perf_counters.sv
// Performance monitor beside the pipelined core: counts cycles and branch/jump
// prediction outcomes until the halt PC or the cycle budget, with a 1-cycle read port.
module ucsbece154b_perf_counters
  import ucsbece154b_perf_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter logic [31:0] HALT_PC    = 32'h00010064,
  parameter int          MAX_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic [31:0] PCF_i,
  input  logic        StallE_i,
  input  logic        BranchE_i,
  input  logic        JumpE_i,
  input  logic        PCSrcE_i,
  input  logic        BranchTakenE_i,
  input  logic        rd_en_i,
  input  logic [2:0]  rd_addr_i,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        done_o
);

  state_e             state_q, state_d;
  logic               timeout_q, timeout_d;
  logic               ovf_q, ovf_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] sat;
  logic [CNT_W-1:0]   cnt_q [NUM_CNT];

  logic               run;
  logic               budget_hit;
  logic               pc_hit;
  logic [32:0]        cyc_inc;

  function automatic logic [31:0] zext(input logic [CNT_W-1:0] v);
    return 32'(v);
  endfunction

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    ucsbece154b_sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc[g]),
      .clr   (clear_i),
      .q     (cnt_q[g]),
      .sat   (sat[g])
    );
  end

  assign run        = (state_q == ST_RUN);
  // Budget compare is done 33 bits wide so a narrow saturated cycle count never aliases
  assign cyc_inc    = {1'b0, zext(cnt_q[CNT_CYC])} + 33'd1;
  assign budget_hit = run && (cyc_inc == 33'(MAX_CYCLES));
  assign pc_hit     = run && (PCF_i == HALT_PC);

  always_comb begin
    inc               = '0;
    inc[CNT_CYC]      = run;
    inc[CNT_BR_TOT]   = run && BranchE_i && !StallE_i;
    inc[CNT_BR_MISS]  = run && BranchE_i && !StallE_i && (PCSrcE_i != BranchTakenE_i);
    inc[CNT_JMP_TOT]  = run && JumpE_i && !StallE_i;
    inc[CNT_JMP_MISS] = run && JumpE_i && !StallE_i && !BranchTakenE_i;

    state_d   = state_q;
    timeout_d = timeout_q;
    ovf_d     = ovf_q || |(inc & sat);
    if (pc_hit || budget_hit) state_d = ST_HALTED;
    if (budget_hit) timeout_d = 1'b1;
    if (clear_i) begin
      state_d   = ST_RUN;
      timeout_d = 1'b0;
      ovf_d     = 1'b0;
    end

    rd_valid_d = rd_en_i;
    rd_data_d  = rd_data_q;
    if (rd_en_i) begin
      case (rd_addr_i)
        ADDR_CYC:      rd_data_d = zext(cnt_q[CNT_CYC]);
        ADDR_BR_TOT:   rd_data_d = zext(cnt_q[CNT_BR_TOT]);
        ADDR_BR_MISS:  rd_data_d = zext(cnt_q[CNT_BR_MISS]);
        ADDR_JMP_TOT:  rd_data_d = zext(cnt_q[CNT_JMP_TOT]);
        ADDR_JMP_MISS: rd_data_d = zext(cnt_q[CNT_JMP_MISS]);
        ADDR_STATUS:   rd_data_d = pack_status(ovf_q, timeout_q, state_q == ST_HALTED);
        ADDR_HALT_PC:  rd_data_d = HALT_PC;
        ADDR_ZERO:     rd_data_d = 32'h0;
        default:       rd_data_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      timeout_q  <= 1'b0;
      ovf_q      <= 1'b0;
      rd_data_q  <= 32'h0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timeout_q  <= timeout_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign done_o     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ucsbece154b_perf_counters.sv
// Bench for the performance monitor: a 32-bit and a 4-bit instance share stimulus and
// are compared against an arithmetic reference model of the counting rules.
module tb_ucsbece154b_perf_counters;

  localparam logic [31:0] HALT = 32'h00010064;
  localparam int          MAXC = 500;

  logic        clk;
  logic        reset, clear_i;
  logic [31:0] pcf;
  logic        stall, br, jmp, pcsrc, pred;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data [2];
  logic        rd_valid [2];
  logic        done [2];

  int checks = 0;
  int errors = 0;

  longint unsigned mcnt [2][5];
  longint unsigned mmax [2];
  bit              movf [2];
  bit              mto [2];
  bit              mhalt [2];
  logic [31:0]     mexp [2];

  ucsbece154b_perf_counters #(.CNT_W(32), .HALT_PC(HALT), .MAX_CYCLES(MAXC)) dut_w (
    .clk(clk), .reset(reset), .clear_i(clear_i), .PCF_i(pcf), .StallE_i(stall),
    .BranchE_i(br), .JumpE_i(jmp), .PCSrcE_i(pcsrc), .BranchTakenE_i(pred),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[0]),
    .rd_valid_o(rd_valid[0]), .done_o(done[0])
  );

  ucsbece154b_perf_counters #(.CNT_W(4), .HALT_PC(HALT), .MAX_CYCLES(MAXC)) dut_n (
    .clk(clk), .reset(reset), .clear_i(clear_i), .PCF_i(pcf), .StallE_i(stall),
    .BranchE_i(br), .JumpE_i(jmp), .PCSrcE_i(pcsrc), .BranchTakenE_i(pred),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[1]),
    .rd_valid_o(rd_valid[1]), .done_o(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input int i, input logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: return 32'(mcnt[i][a]);
      3'd5:    return {29'b0, movf[i], mto[i], mhalt[i]};
      3'd6:    return HALT;
      default: return 32'h0;
    endcase
  endfunction

  // Applies one clock's worth of the counting rules to the model, from current inputs
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit ev [5];
      bit to_hit;
      bit stop;
      if (!reset) mexp[i] = 32'h0;
      else if (rd_en) mexp[i] = model_read(i, rd_addr);
      if (!reset || clear_i) begin
        for (int k = 0; k < 5; k++) mcnt[i][k] = 0;
        movf[i] = 0; mto[i] = 0; mhalt[i] = 0;
      end else if (!mhalt[i]) begin
        ev[0] = 1;
        ev[1] = br && !stall;
        ev[2] = ev[1] && (pcsrc != pred);
        ev[3] = jmp && !stall;
        ev[4] = ev[3] && !pred;
        to_hit = (mcnt[i][0] + 1 == longint'(MAXC));
        stop   = (pcf == HALT) || to_hit;
        for (int k = 0; k < 5; k++) begin
          if (ev[k]) begin
            if (mcnt[i][k] == mmax[i]) movf[i] = 1;
            else mcnt[i][k] = mcnt[i][k] + 1;
          end
        end
        if (to_hit) mto[i] = 1;
        if (stop) mhalt[i] = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_events();
    br = 0; jmp = 0; stall = 0; pcsrc = 0; pred = 0;
  endtask

  task automatic rand_events();
    br    = 1'($urandom_range(0, 1));
    jmp   = 1'($urandom_range(0, 2) == 0);
    stall = 1'($urandom_range(0, 3) == 0);
    pcsrc = 1'($urandom_range(0, 1));
    pred  = 1'($urandom_range(0, 1));
  endtask

  task automatic read_reg(input logic [2:0] a);
    rd_en = 1; rd_addr = a;
    tick();
    rd_en = 0;
  endtask

  task automatic do_clear();
    clear_i = 1;
    tick();
    clear_i = 0;
  endtask

  task automatic shuffle6(output int p [6]);
    for (int k = 0; k < 6; k++) p[k] = k;
    for (int k = 5; k > 0; k--) begin
      int j, t;
      j = int'($urandom_range(0, k));
      t = p[k]; p[k] = p[j]; p[j] = t;
    end
  endtask

  task automatic test_reset();
    reset = 0;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_data[i] !== 32'h0 || rd_valid[i] !== 1'b0 || done[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: got data=%h valid=%b done=%b want 0/0/0",
                 i, rd_data[i], rd_valid[i], done[i]);
      end
    end
    reset = 1;
    repeat (10) tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_valid[i] !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid inst%0d: got %b want 0", i, rd_valid[i]);
      end
    end
    read_reg(3'd0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_valid[i] !== 1'b1 || rd_data[i] !== 32'd10 || rd_data[i] !== mexp[i]) begin
        errors++;
        $display("FAIL idle_cyc inst%0d: got valid=%b data=%0d want 1/10 (model %0d)",
                 i, rd_valid[i], rd_data[i], mexp[i]);
      end
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_valid[i] !== 1'b0 || rd_data[i] !== 32'd10) begin
        errors++;
        $display("FAIL valid_pulse_hold inst%0d: got valid=%b data=%0d want 0/10",
                 i, rd_valid[i], rd_data[i]);
      end
    end
    read_reg(3'd5);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_data[i] !== 32'h0 || rd_data[i] !== mexp[i]) begin
        errors++;
        $display("FAIL idle_status inst%0d: got %h want 0", i, rd_data[i]);
      end
    end
  endtask

  task automatic test_branches();
    int p [6];
    int exp_miss;
    do_clear();
    shuffle6(p);
    for (int k = 0; k < 6; k++) begin
      br = 1; pred = 1; pcsrc = (p[k] < 4);
      tick();
    end
    idle_events();
    read_reg(3'd1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_data[i] !== 32'd6 || rd_data[i] !== mexp[i]) begin
        errors++;
        $display("FAIL br_tot inst%0d: got %0d want 6", i, rd_data[i]);
      end
    end
    read_reg(3'd2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_data[i] !== 32'd2 || rd_data[i] !== mexp[i]) begin
        errors++;
        $display("FAIL br_miss inst%0d: got %0d want 2", i, rd_data[i]);
      end
    end
    do_clear();
    shuffle6(p);
    exp_miss = 0;
    for (int k = 0; k < 6; k++) begin
      br = 1; pred = 1; pcsrc = (k < 4); stall = (p[k] < 3);
      if (!stall && k >= 4) exp_miss++;
      tick();
    end
    idle_events();
    read_reg(3'd1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_data[i] !== 32'd3 || rd_data[i] !== mexp[i]) begin
        errors++;
        $display("FAIL br_tot_stall inst%0d: got %0d want 3", i, rd_data[i]);
      end
    end
    read_reg(3'd2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_data[i] !== 32'(exp_miss) || rd_data[i] !== mexp[i]) begin
        errors++;
        $display("FAIL br_miss_stall inst%0d: got %0d want %0d", i, rd_data[i], exp_miss);
      end
    end
  endtask

  task automatic test_jumps();
    int p [6];
    do_clear();
    shuffle6(p);
    for (int k = 0; k < 6; k++) begin
      if (p[k] < 4) begin
        jmp = 1; pred = (p[k] < 3);
      end else begin
        jmp = 0; pred = 1'($urandom_range(0, 1));
      end
      tick();
    end
    idle_events();
    read_reg(3'd3);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_data[i] !== 32'd4 || rd_data[i] !== mexp[i]) begin
        errors++;
        $display("FAIL jmp_tot inst%0d: got %0d want 4", i, rd_data[i]);
      end
    end
    read_reg(3'd4);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_data[i] !== 32'd1 || rd_data[i] !== mexp[i]) begin
        errors++;
        $display("FAIL jmp_miss inst%0d: got %0d want 1", i, rd_data[i]);
      end
    end
  endtask

  task automatic test_halt_pc();
    logic [31:0] want [4];
    logic [2:0]  addr [4];
    do_clear();
    pcf = 32'h0;
    repeat (6) tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (done[i] !== 1'b0) begin
        errors++;
        $display("FAIL done_before_halt inst%0d: got %b want 0", i, done[i]);
      end
    end
    pcf = HALT; br = 1; pred = 1; pcsrc = 0;
    tick();
    pcf = 32'h00000040;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (done[i] !== 1'b1) begin
        errors++;
        $display("FAIL done_after_halt inst%0d: got %b want 1", i, done[i]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      rand_events();
      tick();
    end
    idle_events();
    addr = '{3'd0, 3'd1, 3'd2, 3'd5};
    want = '{32'd7, 32'd1, 32'd1, 32'd1};
    for (int a = 0; a < 4; a++) begin
      read_reg(addr[a]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rd_data[i] !== want[a] || rd_data[i] !== mexp[i]) begin
          errors++;
          $display("FAIL halt_read_addr%0d inst%0d: got %0d want %0d",
                   addr[a], i, rd_data[i], want[a]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    do_clear();
    pcf = 32'h0;
    n = 0;
    while (done[0] !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    checks++;
    if (n != 500) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d cycles to done want 500", n);
    end
    read_reg(3'd0);
    checks++;
    if (rd_data[0] !== 32'd500 || rd_data[0] !== mexp[0]) begin
      errors++;
      $display("FAIL timeout_cyc: got %0d want 500", rd_data[0]);
    end
    read_reg(3'd5);
    checks++;
    if (rd_data[0] !== 32'd3 || rd_data[0] !== mexp[0]) begin
      errors++;
      $display("FAIL timeout_status: got %h want 3", rd_data[0]);
    end
    checks++;
    if (rd_data[1] !== 32'd4 || rd_data[1] !== mexp[1]) begin
      errors++;
      $display("FAIL narrow_status_long: got %h want 4", rd_data[1]);
    end
    clear_i = 1;
    tick();
    for (int a = 0; a < 6; a++) begin
      read_reg(3'(a));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rd_data[i] !== 32'h0 || rd_data[i] !== mexp[i]) begin
          errors++;
          $display("FAIL cleared_addr%0d inst%0d: got %h want 0", a, i, rd_data[i]);
        end
      end
    end
    clear_i = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (done[i] !== 1'b0) begin
        errors++;
        $display("FAIL cleared_done inst%0d: got %b want 0", i, done[i]);
      end
    end
  endtask

  task automatic test_narrow_sat();
    do_clear();
    repeat (20) tick();
    read_reg(3'd0);
    checks++;
    if (rd_data[1] !== 32'd15 || rd_data[1] !== mexp[1]) begin
      errors++;
      $display("FAIL narrow_cyc_sat: got %0d want 15", rd_data[1]);
    end
    checks++;
    if (rd_data[0] !== 32'd20 || rd_data[0] !== mexp[0]) begin
      errors++;
      $display("FAIL wide_cyc_20: got %0d want 20", rd_data[0]);
    end
    read_reg(3'd5);
    checks++;
    if (rd_data[1][2] !== 1'b1 || rd_data[1] !== mexp[1]) begin
      errors++;
      $display("FAIL narrow_ovf: got status %h want ovf bit set (model %h)",
               rd_data[1], mexp[1]);
    end
    clear_i = 1; br = 1; pred = 0; pcsrc = 1; jmp = 1;
    tick();
    clear_i = 0;
    idle_events();
    read_reg(3'd1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_data[i] !== 32'h0 || rd_data[i] !== mexp[i]) begin
        errors++;
        $display("FAIL clear_beats_event inst%0d: got %0d want 0", i, rd_data[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int k = 0; k < 20; k++) begin
      rand_events();
      tick();
    end
    for (int a = 0; a < 8; a++) begin
      rand_events();
      rd_en = 1; rd_addr = 3'(a);
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rd_valid[i] !== 1'b1 || rd_data[i] !== mexp[i]) begin
          errors++;
          $display("FAIL b2b_addr%0d inst%0d: got valid=%b data=%h want 1/%h",
                   a, i, rd_valid[i], rd_data[i], mexp[i]);
        end
      end
    end
    rd_en = 0;
    idle_events();
  endtask

  task automatic test_random();
    bit pend;
    do_clear();
    for (int n = 0; n < 400; n++) begin
      rand_events();
      pcf     = ($urandom_range(0, 99) == 0) ? HALT : $urandom;
      clear_i = 1'($urandom_range(0, 49) == 0);
      rd_en   = 1'($urandom_range(0, 2) == 0);
      rd_addr = 3'($urandom_range(0, 7));
      pend    = rd_en;
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rd_valid[i] !== pend || rd_data[i] !== mexp[i] || done[i] !== mhalt[i]) begin
          errors++;
          $display("FAIL random_c%0d inst%0d: got valid=%b data=%h done=%b want %b/%h/%b",
                   n, i, rd_valid[i], rd_data[i], done[i], pend, mexp[i], mhalt[i]);
        end
      end
    end
    clear_i = 0; rd_en = 0; pcf = 32'h0;
    idle_events();
  endtask

  initial begin
    mmax[0] = 64'hFFFF_FFFF;
    mmax[1] = 64'd15;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 5; k++) mcnt[i][k] = 0;
      movf[i] = 0; mto[i] = 0; mhalt[i] = 0; mexp[i] = 32'h0;
    end
    reset = 0; clear_i = 0; pcf = 32'h0; rd_en = 0; rd_addr = 3'd0;
    idle_events();
    @(posedge clk);
    #1;
    test_reset();
    test_branches();
    test_jumps();
    test_halt_pc();
    test_timeout();
    test_narrow_sat();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
